// File: rtl/aes_round_ctrl_if.sv
// Bus bundle for the AES round controller: host block handshake on one side,
// round-datapath issue/return on the other.
//
// Handshake semantics (all sampled on the rising clock edge):
//   - A host block transfers on an edge where vin=1 and ready=1; vin seen
//     while ready=0 is dropped, never queued.
//   - rnd_vin is a one-cycle issue strobe; rnd_in/round_idx stay stable from
//     the issue until the result is taken.
//   - A round result transfers on an edge where rnd_vout=1 while a round is
//     outstanding; rnd_vout at any other time is ignored.
//   - vout is a one-cycle pulse with no backpressure; dout holds afterwards.
interface aes_round_ctrl_if;
  logic         vin;
  logic [127:0] din;
  logic         ready;
  logic [127:0] rnd_in;
  logic         rnd_vin;
  logic [3:0]   round_idx;
  logic         last_round;
  logic         first_round;
  logic [127:0] rnd_out;
  logic         rnd_vout;
  logic [127:0] dout;
  logic         vout;

  // Environment side: host plus round datapath.
  modport master (
    output vin, din, rnd_out, rnd_vout,
    input  ready, rnd_in, rnd_vin, round_idx, last_round, first_round,
           dout, vout
  );

  // Controller side.
  modport slave (
    input  vin, din, rnd_out, rnd_vout,
    output ready, rnd_in, rnd_vin, round_idx, last_round, first_round,
           dout, vout
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: takes one plaintext block, issues NR+1 rounds to an
// external round datapath of arbitrary latency, and returns the ciphertext.
// NR must fit the 4-bit round index (1..15).
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_RC = 4'(NR);

  state_t       state_q;
  logic [127:0] st_q;
  logic [3:0]   rc_q;
  logic [127:0] dout_q;
  logic         vout_q;
  logic         rnd_vin_q;
  logic         ready_q;
  logic         busy;

  // A round is outstanding in ISSUE and WAIT; the round flags only mean
  // something there, so they are forced low elsewhere.
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.first_round = busy && (rc_q == 4'd0);
  assign bus.last_round  = busy && (rc_q == LAST_RC);

  // The datapath operand and key select come straight from the state
  // registers, so they stay stable for as long as the round is outstanding.
  assign bus.rnd_in    = st_q;
  assign bus.round_idx = rc_q;
  assign bus.rnd_vin   = rnd_vin_q;
  assign bus.ready     = ready_q;
  assign bus.dout      = dout_q;
  assign bus.vout      = vout_q;
  assign dbg_state_o   = state_q;

  // Sequencer FSM with all strobes registered one cycle ahead of their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      st_q      <= '0;
      rc_q      <= 4'd0;
      dout_q    <= '0;
      vout_q    <= 1'b0;
      rnd_vin_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      vout_q    <= 1'b0;
      rnd_vin_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // rnd_vout here is a stale or spurious datapath pulse: ignore it.
          if (bus.vin) begin
            st_q      <= bus.din;
            rc_q      <= 4'd0;
            state_q   <= S_ISSUE;
            rnd_vin_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        S_ISSUE, S_WAIT: begin
          // One acceptance per visit: leaving for ISSUE or DONE on every
          // acceptance means a stuck-high rnd_vout cannot skip rounds.
          if (bus.rnd_vout) begin
            st_q <= bus.rnd_out;
            if (rc_q == LAST_RC) begin
              state_q <= S_DONE;
              dout_q  <= bus.rnd_out;
              vout_q  <= 1'b1;
            end else begin
              rc_q      <= rc_q + 4'd1;
              state_q   <= S_ISSUE;
              rnd_vin_q <= 1'b1;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          // vin during DONE is dropped; ready rises for the next cycle.
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: an AES-128 round datapath model with selectable
// latency, FIPS-197 vector table, random blocks against a whole-cipher
// reference, and hand sequences for busy-vin, mid-block reset and junk
// rnd_vout pulses.
module tb_aes_round_ctrl;

  localparam int NR_TB = 10;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  aes_round_ctrl_if bus();

  aes_round_ctrl #(.NR(NR_TB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox [0:255];
  logic [127:0] rk   [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Byte i of the state is bits [127-8i -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [7:0]   a [0:15];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127 - 8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = a[r + 4*((c + r) % 4)];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103 - 32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  // One datapath round, steered by the controller's flags and key index.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [3:0] idx,
                                            input logic first, input logic last);
    logic [127:0] t;
    if (idx > 4'd10) return ~s;
    if (first) return s ^ rk[idx];
    t = sub_shift(s);
    if (!last) t = mix(t);
    return t ^ rk[idx];
  endfunction

  // Whole-cipher reference: AES-128 encryption with the current key schedule.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR_TB; r++) begin
      s = sub_shift(s);
      if (r != NR_TB) s = mix(s);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // ---------------- datapath model + monitor (negedge) ----------------
  typedef struct { int due; logic [127:0] data; } pend_t;
  pend_t pq[$];
  int dp_lat    = 0;
  int junk_mode = 0;   // 0 none, 1 random pulses, 2 stuck high
  int issue_n   = 0;
  int vout_cnt  = 0;
  int ncyc      = 0;

  always @(negedge clk) begin
    logic [127:0] r;
    pend_t        p;
    ncyc++;
    if (bus.vout) begin
      vout_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_vout: got vout with dout %h, expected none", bus.dout);
      end else begin
        chk("sb_dout", bus.dout, exp_q.pop_front());
      end
    end
    if (bus.rnd_vin) begin
      chk("round_idx", 128'(bus.round_idx), 128'(issue_n));
      chk("first_round", 128'(bus.first_round), 128'(issue_n == 0));
      chk("last_round", 128'(bus.last_round), 128'(issue_n == NR_TB));
      r = round_fn(bus.rnd_in, bus.round_idx, bus.first_round, bus.last_round);
      p.due = ncyc + dp_lat;
      p.data = r;
      pq.push_back(p);
      issue_n++;
    end
    bus.rnd_vout = 1'b0;
    bus.rnd_out  = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (pq.size() > 0 && pq[0].due <= ncyc) begin
      bus.rnd_vout = 1'b1;
      bus.rnd_out  = pq[0].data;
      void'(pq.pop_front());
    end else if (junk_mode == 2) begin
      bus.rnd_vout = 1'b1;
    end else if (junk_mode == 1) begin
      bus.rnd_vout = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- driver tasks (called right after a negedge) ----------------
  task automatic start_block(input logic [127:0] pt, input logic [127:0] exp, output int t_acc);
    int n;
    n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", 128'(bus.ready), 128'(1));
    issue_n = 0;
    exp_q.push_back(exp);
    bus.vin = 1'b1;
    bus.din = pt;
    t_acc = cyc + 1;
    @(negedge clk);
    bus.vin = 1'b0;
    bus.din = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_vout(output bit got, output int edge_n);
    int n;
    n = 0; got = 1'b0; edge_n = 0;
    while (!got && n < 400) begin
      if (bus.vout) begin
        got = 1'b1;
        edge_n = cyc + 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic check_block(input string name, input int t_acc, input int lat, input logic [127:0] exp);
    bit got;
    int e;
    wait_vout(got, e);
    chk({name, "_vout_seen"}, 128'(got), 128'(1));
    if (got) begin
      chk({name, "_vout_edge"}, 128'(e), 128'(t_acc + 1 + (NR_TB + 1) * (lat + 1)));
      chk({name, "_dout"}, bus.dout, exp);
      chk({name, "_issues"}, 128'(issue_n), 128'(NR_TB + 1));
      @(negedge clk);
      chk({name, "_vout_pulse"}, 128'(bus.vout), 128'(0));
      chk({name, "_dout_hold"}, bus.dout, exp);
      chk({name, "_ready_after"}, 128'(bus.ready), 128'(1));
    end
  endtask

  task automatic run_vec(input string name, input logic [127:0] key, input logic [127:0] pt,
                         input int lat, input logic [127:0] exp, input bit has_exp);
    int t;
    logic [127:0] e;
    expand_key(key);
    dp_lat = lat;
    e = has_exp ? exp : aes_ref(pt);
    start_block(pt, e, t);
    check_block(name, t, lat, e);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    int           lat;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [0:3];

  // ---------------- main sequence ----------------
  initial begin
    int t, ta, tb_acc, e, n, vc0;
    bit got;
    logic [127:0] k, pa, pb, ea, eb;

    rst = 1'b1;
    bus.vin = 1'b0;
    bus.din = '0;
    build_sbox();

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                lat: 0, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                lat: 3, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                lat: 1, ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                lat: 5, ct: 128'h3925841d02dc09fbdc118597196a0b32};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 128'(bus.ready), 128'(1));
    chk("rst_vout", 128'(bus.vout), 128'(0));
    chk("rst_rnd_vin", 128'(bus.rnd_vin), 128'(0));
    chk("rst_round_idx", 128'(bus.round_idx), 128'(0));
    chk("rst_dout", bus.dout, 128'h0);
    chk("rst_state_idle", 128'(dbg_state), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven known-answer vectors.
    for (int i = 0; i < 4; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].lat, vecs[i].ct, 1'b1);

    // Random blocks against the reference cipher.
    for (int i = 0; i < 6; i++)
      run_vec($sformatf("rand%0d", i), rnd128(), rnd128(), int'($urandom_range(0, 4)), '0, 1'b0);

    // vin hammered while busy: one vout per block, next block only from IDLE.
    k = rnd128(); pa = rnd128(); pb = rnd128();
    expand_key(k);
    dp_lat = 2;
    ea = aes_ref(pa);
    eb = aes_ref(pb);
    vc0 = vout_cnt;
    start_block(pa, ea, ta);
    n = 0; got = 1'b0; e = 0;
    while (!got && n < 400) begin
      if (bus.vout) begin
        got = 1'b1;
        e = cyc + 1;
      end else begin
        bus.vin = 1'b1;
        bus.din = rnd128();
        @(negedge clk);
        n++;
      end
    end
    chk("hammer_a_vout_seen", 128'(got), 128'(1));
    chk("hammer_a_vout_edge", 128'(e), 128'(ta + 1 + (NR_TB + 1) * 3));
    chk("hammer_a_dout", bus.dout, ea);
    issue_n = 0;
    exp_q.push_back(eb);
    bus.vin = 1'b1;
    bus.din = pb;
    tb_acc = cyc + 2;
    @(negedge clk);
    chk("hammer_idle_ready", 128'(bus.ready), 128'(1));
    chk("hammer_idle_rnd_vin", 128'(bus.rnd_vin), 128'(0));
    @(negedge clk);
    bus.vin = 1'b0;
    check_block("hammer_b", tb_acc, 2, eb);
    chk("hammer_vout_count", 128'(vout_cnt - vc0), 128'(2));

    // Reset during round 5 with L=2: block abandoned, next block clean.
    k = rnd128(); pa = rnd128();
    expand_key(k);
    dp_lat = 2;
    vc0 = vout_cnt;
    start_block(pa, aes_ref(pa), t);
    n = 0;
    while (!(bus.rnd_vin && bus.round_idx == 4'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_r5", 128'(bus.round_idx), 128'(5));
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_ready", 128'(bus.ready), 128'(1));
    chk("rst_mid_vout", 128'(bus.vout), 128'(0));
    chk("rst_mid_rnd_vin", 128'(bus.rnd_vin), 128'(0));
    chk("rst_mid_round_idx", 128'(bus.round_idx), 128'(0));
    chk("rst_mid_dout", bus.dout, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_mid_idle_ready", 128'(bus.ready), 128'(1));
    end
    chk("rst_mid_no_vout", 128'(vout_cnt - vc0), 128'(0));
    run_vec("post_rst", k, rnd128(), 2, '0, 1'b0);

    // Spurious rnd_vout in IDLE, then rnd_vout stuck high through a block.
    k = rnd128(); pa = rnd128();
    expand_key(k);
    dp_lat = 0;
    junk_mode = 1;
    repeat (12) begin
      @(negedge clk);
      chk("junk_idle_ready", 128'(bus.ready), 128'(1));
      chk("junk_idle_rnd_vin", 128'(bus.rnd_vin), 128'(0));
    end
    junk_mode = 2;
    @(negedge clk);
    start_block(pa, aes_ref(pa), t);
    check_block("stuck", t, 0, aes_ref(pa));
    junk_mode = 0;

    repeat (4) @(negedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
